// File: rtl/instrumented_adder_sweep.sv
// Sweep sequencer for the instrumented adder: walks the ring insertion point and counts oscillations per bit.
// Optional macro INSTR_ADDER_SATURATE_EN selects a saturating counter with per-entry overflow flags.
module instrumented_adder_sweep #(
  parameter int WIDTH  = 32,
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 16,
  parameter int SETTLE = 4
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     start,
  input  logic [$clog2(WIDTH)-1:0] first_bit,
  input  logic [$clog2(WIDTH)-1:0] last_bit,
  input  logic [WIN_W-1:0]         window,
  input  logic                     chain_out,
  output logic [WIDTH-1:0]         ring_bit_b,
  output logic                     ring_en,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  input  logic [$clog2(WIDTH)-1:0] rd_addr,
  output logic [CNT_W-1:0]         rd_data,
  output logic [WIDTH-1:0]         ovf
);

  localparam int AW = $clog2(WIDTH);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = (WIN_W > SW) ? WIN_W : SW;

  typedef enum logic [2:0] {IDLE, SETUP, RUN, STORE, NEXT, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [AW-1:0]    cur_bit;
  logic [AW-1:0]    last_q;
  logic [WIN_W-1:0] win_q;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic [2:0]       sync;
  logic             rise;
  logic             settle_done;
  logic             run_done;
  logic             accept;
  logic             clear_cnt;
  logic [CNT_W-1:0] res_buf [WIDTH];

  // sync[1:0] is the two-flop synchroniser; sync[2] holds the previous synchronised level
  assign rise        = sync[1] & ~sync[2];
  assign settle_done = (timer == TW'(SETTLE - 1));
  assign run_done    = (timer == TW'(win_q) - TW'(1));
  assign accept      = (state == IDLE) && start;
  assign clear_cnt   = accept || (state == NEXT);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (first_bit > last_bit) ? DONE : SETUP;
      SETUP:   if (settle_done) state_nxt = (win_q == '0) ? STORE : RUN;
      RUN:     if (run_done) state_nxt = STORE;
      STORE:   state_nxt = NEXT;
      NEXT:    state_nxt = (cur_bit == last_q) ? DONE : SETUP;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ring_bit_b = '1;
    ring_en    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      SETUP, STORE, NEXT: begin
        ring_bit_b = ~(WIDTH'(1) << cur_bit);
        busy       = 1'b1;
      end
      RUN: begin
        ring_bit_b = ~(WIDTH'(1) << cur_bit);
        ring_en    = 1'b1;
        busy       = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // The phase timer restarts on every state change, so SETUP and RUN each measure from zero
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      timer   <= '0;
      sync    <= '0;
      cur_bit <= '0;
      last_q  <= '0;
      win_q   <= '0;
      err     <= 1'b0;
      rd_data <= '0;
      for (int i = 0; i < WIDTH; i++) res_buf[i] <= '0;
    end else begin
      timer   <= (state_nxt != state) ? '0 : timer + TW'(1);
      sync    <= {sync[1:0], chain_out};
      rd_data <= res_buf[rd_addr];
      if (accept) begin
        err     <= (first_bit > last_bit);
        cur_bit <= first_bit;
        last_q  <= last_bit;
        win_q   <= window;
      end
      if (state == STORE) res_buf[cur_bit] <= count;
      if ((state == NEXT) && (cur_bit != last_q)) cur_bit <= cur_bit + AW'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)                     count <= '0;
    else if (clear_cnt)               count <= '0;
    else if ((state == RUN) && rise)  count <= count_inc;
  end

`ifdef INSTR_ADDER_SATURATE_EN
  logic             sat_flag;
  logic [WIDTH-1:0] ovf_q;

  assign count_inc = (count == '1) ? count : count + CNT_W'(1);
  assign ovf       = ovf_q;

  // An edge arriving while the count is already at full scale marks the entry as overflowed
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sat_flag <= 1'b0;
      ovf_q    <= '0;
    end else begin
      if (clear_cnt)                                         sat_flag <= 1'b0;
      else if ((state == RUN) && rise && (count == '1))      sat_flag <= 1'b1;
      if (state == STORE) ovf_q[cur_bit] <= sat_flag;
    end
  end
`else
  assign count_inc = count + CNT_W'(1);
  assign ovf       = '0;
`endif

endmodule

// File: tb/tb_instrumented_adder_sweep.sv
// Randomised self-checking bench for instrumented_adder_sweep; a 32-bit and a small 8-bit/4-bit-count instance.
module tb_instrumented_adder_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        chain_out;
  logic        start;
  logic [4:0]  first_bit, last_bit, rd_addr;
  logic [15:0] window;
  logic [31:0] ring_bit_b, ovf;
  logic        ring_en, busy, done, err;
  logic [15:0] rd_data;

  logic        s_start;
  logic [2:0]  s_first, s_last, s_rd_addr;
  logic [7:0]  s_window;
  logic [7:0]  s_ring_bit_b, s_ovf;
  logic        s_ring_en, s_busy, s_done, s_err;
  logic [3:0]  s_rd_data;

  instrumented_adder_sweep #(.WIDTH(32), .CNT_W(16), .WIN_W(16), .SETTLE(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .first_bit(first_bit), .last_bit(last_bit),
    .window(window), .chain_out(chain_out), .ring_bit_b(ring_bit_b), .ring_en(ring_en),
    .busy(busy), .done(done), .err(err), .rd_addr(rd_addr), .rd_data(rd_data), .ovf(ovf));

  instrumented_adder_sweep #(.WIDTH(8), .CNT_W(4), .WIN_W(8), .SETTLE(2)) dut_small (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(s_start), .first_bit(s_first), .last_bit(s_last),
    .window(s_window), .chain_out(chain_out), .ring_bit_b(s_ring_bit_b), .ring_en(s_ring_en),
    .busy(s_busy), .done(s_done), .err(s_err), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .ovf(s_ovf));

  int          use_small = 0;
  logic [31:0] mx_rbb, mx_ovf;
  logic [15:0] mx_rd;
  logic        mx_en, mx_busy, mx_done, mx_err;

  always_comb begin
    if (use_small != 0) begin
      mx_rbb = {24'hFFFFFF, s_ring_bit_b}; mx_ovf = {24'd0, s_ovf}; mx_rd = {12'd0, s_rd_data};
      mx_en = s_ring_en; mx_busy = s_busy; mx_done = s_done; mx_err = s_err;
    end else begin
      mx_rbb = ring_bit_b; mx_ovf = ovf; mx_rd = rd_data;
      mx_en = ring_en; mx_busy = busy; mx_done = done; mx_err = err;
    end
  end

  int errors = 0;
  int checks = 0;
  int half   = 4;
  int exp_lo  [2][32];
  int exp_hi  [2][32];
  bit exp_ovf [2][32];

  // Free-running square wave standing in for the ring; period is 2*half clocks
  initial begin
    chain_out = 1'b0;
    forever begin
      repeat (half) @(posedge clk);
      #2 chain_out = ~chain_out;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached, required finish earlier");
    $fatal(1);
  end

  task automatic clear_model(input int sel);
    for (int i = 0; i < 32; i++) begin
      exp_lo[sel][i] = 0; exp_hi[sel][i] = 0; exp_ovf[sel][i] = 1'b0;
    end
  endtask

  // A window of w clocks sees floor or ceil of w/period ring rising edges
  task automatic model_sweep(input int sel, input int fb, input int lb, input int w, input int period);
    int m  = 1 << (sel != 0 ? 4 : 16);
    int lo = w / period;
    int hi = (w + period - 1) / period;
    for (int p = fb; p <= lb; p++) begin
`ifdef INSTR_ADDER_SATURATE_EN
      exp_lo[sel][p]  = (lo > m - 1) ? m - 1 : lo;
      exp_hi[sel][p]  = (hi > m - 1) ? m - 1 : hi;
      exp_ovf[sel][p] = (lo >= m);
`else
      exp_lo[sel][p]  = lo % m;
      exp_hi[sel][p]  = hi % m;
      exp_ovf[sel][p] = 1'b0;
`endif
    end
  endtask

  task automatic drive_start(input int sel, input int fb, input int lb, input int w);
    if (sel != 0) begin
      s_first = 3'(fb); s_last = 3'(lb); s_window = 8'(w); s_start = 1'b1;
    end else begin
      first_bit = 5'(fb); last_bit = 5'(lb); window = 16'(w); start = 1'b1;
    end
  endtask

  task automatic drop_start();
    start = 1'b0; s_start = 1'b0;
  endtask

  task automatic check_buffer(input int sel, input string tag);
    int n = (sel != 0) ? 8 : 32;
    int v;
    use_small = sel;
    for (int i = 0; i < n; i++) begin
      if (sel != 0) s_rd_addr = 3'(i); else rd_addr = 5'(i);
      @(negedge clk);
      v = int'(mx_rd);
      checks++;
      if ($isunknown(mx_rd) || v < exp_lo[sel][i] || v > exp_hi[sel][i]) begin
        errors++;
        $display("[TB] FAIL %s buf[%0d]: got %0d, required %0d..%0d", tag, i, v, exp_lo[sel][i], exp_hi[sel][i]);
      end
      checks++;
      if (mx_ovf[i] !== exp_ovf[sel][i]) begin
        errors++;
        $display("[TB] FAIL %s ovf[%0d]: got %b, required %b", tag, i, mx_ovf[i], exp_ovf[sel][i]);
      end
    end
  endtask

  // Runs one sweep and checks cycle-by-cycle select/enable/busy plus done timing and err
  task automatic sweep(input int sel, input int fb, input int lb, input int w, input int h,
                       input bit poke, input string tag);
    int settle = (sel != 0) ? 2 : 4;
    int width  = (sel != 0) ? 8 : 32;
    bit bad    = (fb > lb);
    int n      = bad ? 0 : lb - fb + 1;
    int per    = settle + w + 2;
    int exp_done = bad ? 1 : n * per + 1;
    int walk_err = 0, en_err = 0, busy_err = 0, done_cnt = 0, done_cyc = -1;
    int p, o;
    bit exp_en, exp_busy;
    logic [31:0] exp_rbb;
    use_small = sel;
    half = h;
    repeat (16) @(negedge clk);
    drive_start(sel, fb, lb, w);
    @(negedge clk);
    drop_start();
    for (int cyc = 1; cyc <= exp_done + 8; cyc++) begin
      if (poke && !bad && cyc == 3) drive_start(sel, 0, width - 1, 5);
      if (poke && cyc == 4) drop_start();
      exp_busy = !bad && (cyc < exp_done);
      exp_en   = 1'b0;
      exp_rbb  = 32'hFFFFFFFF;
      if (exp_busy) begin
        p = fb + (cyc - 1) / per;
        o = (cyc - 1) % per;
        exp_en  = (o >= settle) && (o < settle + w);
        exp_rbb = ~(32'd1 << p);
        if (o < settle + w && mx_rbb !== exp_rbb) walk_err++;
      end else if (mx_rbb !== exp_rbb) walk_err++;
      if (mx_en !== exp_en) en_err++;
      if (mx_busy !== exp_busy) busy_err++;
      if (mx_done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      @(negedge clk);
    end
    checks++;
    if (walk_err != 0) begin errors++; $display("[TB] FAIL %s ring_bit_b: %0d wrong cycles, required 0", tag, walk_err); end
    checks++;
    if (en_err != 0) begin errors++; $display("[TB] FAIL %s ring_en: %0d wrong cycles, required 0", tag, en_err); end
    checks++;
    if (busy_err != 0) begin errors++; $display("[TB] FAIL %s busy: %0d wrong cycles, required 0", tag, busy_err); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("[TB] FAIL %s done pulses: got %0d, required 1", tag, done_cnt); end
    checks++;
    if (bad ? (done_cyc < 1 || done_cyc > 2) : (done_cyc != exp_done)) begin
      errors++; $display("[TB] FAIL %s done cycle: got %0d, required %0d", tag, done_cyc, exp_done);
    end
    checks++;
    if (mx_err !== bad) begin errors++; $display("[TB] FAIL %s err: got %b, required %b", tag, mx_err, bad); end
    if (!bad) model_sweep(sel, fb, lb, w, 2 * h);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int sel = 0; sel < 2; sel++) begin
      use_small = sel;
      #1;
      checks++;
      if (mx_rbb !== 32'hFFFFFFFF || mx_en !== 1'b0 || mx_busy !== 1'b0 || mx_done !== 1'b0) begin
        errors++; $display("[TB] FAIL reset ctrl[%0d]: got rbb=%h en=%b busy=%b done=%b, required ffffffff/0/0/0",
                           sel, mx_rbb, mx_en, mx_busy, mx_done);
      end
      checks++;
      if (mx_err !== 1'b0 || mx_ovf !== 32'd0 || mx_rd !== 16'd0) begin
        errors++; $display("[TB] FAIL reset status[%0d]: got err=%b ovf=%h rd=%h, required 0", sel, mx_err, mx_ovf, mx_rd);
      end
    end
    rst = 1'b0;
    clear_model(0); clear_model(1);
    check_buffer(0, "reset");
    check_buffer(1, "reset small");
  endtask

  task automatic test_sweep_basic();
    sweep(0, 3, 5, 20, 4, 1'b1, "basic");
    check_buffer(0, "basic");
  endtask

  task automatic test_range_error();
    sweep(0, 7, 2, 20, 4, 1'b0, "range");
    repeat (5) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin errors++; $display("[TB] FAIL range err sticky: got %b, required 1", err); end
    check_buffer(0, "range");
  endtask

  task automatic test_window_zero();
    sweep(0, 0, 0, 16, 2, 1'b0, "bit0 w16");
    check_buffer(0, "bit0 w16");
    sweep(0, 0, 0, 0, 2, 1'b0, "bit0 w0");
    check_buffer(0, "bit0 w0");
  endtask

  task automatic test_counter_overflow();
    sweep(1, 1, 2, 100, 2, 1'b0, "small ovf");
    sweep(1, 3, 3, 40, 2, 1'b0, "small ok");
    check_buffer(1, "small");
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      int h  = int'($urandom_range(2, 5));
      int fb = int'($urandom_range(0, 28));
      int lb = fb + int'($urandom_range(0, 3));
      int w  = 2 * h * int'($urandom_range(0, 8));
      sweep(0, fb, lb, w, h, 1'b0, "random");
    end
    check_buffer(0, "random");
  endtask

  task automatic test_reset_mid_sweep();
    int bad_done = 0;
    use_small = 0;
    half = 4;
    repeat (16) @(negedge clk);
    drive_start(0, 3, 5, 20);
    @(negedge clk);
    drop_start();
    for (int c = 1; c < 34; c++) begin
      if (done === 1'b1) bad_done++;
      @(negedge clk);
    end
    checks++;
    if (ring_en !== 1'b1 || ring_bit_b !== ~(32'd1 << 4)) begin
      errors++; $display("[TB] FAIL midreset pre: got en=%b rbb=%h, required 1/%h", ring_en, ring_bit_b, ~(32'd1 << 4));
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ring_en !== 1'b0 || ring_bit_b !== 32'hFFFFFFFF || done !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset idle: got busy=%b en=%b rbb=%h done=%b, required 0/0/ffffffff/0",
                         busy, ring_en, ring_bit_b, done);
    end
    rst = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (done === 1'b1 || busy === 1'b1) bad_done++;
      @(negedge clk);
    end
    checks++;
    if (bad_done != 0) begin errors++; $display("[TB] FAIL midreset quiet: got %0d done/busy cycles, required 0", bad_done); end
    clear_model(0); clear_model(1);
    check_buffer(0, "midreset");
    check_buffer(1, "midreset small");
    sweep(0, 3, 5, 20, 4, 1'b0, "after reset");
    check_buffer(0, "after reset");
  endtask

  initial begin
    rst = 1'b1;
    drop_start();
    first_bit = '0; last_bit = '0; window = '0; rd_addr = '0;
    s_first = '0; s_last = '0; s_window = '0; s_rd_addr = '0;
    test_reset();
    test_sweep_basic();
    test_range_error();
    test_window_zero();
    test_counter_overflow();
    test_random();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
